// File: rtl/module_uart_ctrl_bank_pkg.sv
// Shared register layout for the UART control bank.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: bit positions of the per-channel control/status register,
// the RX byte counter width, and a packed struct view of that register.
package pkg_UART;

  // Architectural register width; anything above this reads as zero.
  localparam int REG_W       = 16;

  // Bit positions inside a channel register.
  localparam int SEND_BIT    = 0;
  localparam int NEW_RX_BIT  = 1;
  localparam int OVERRUN_BIT = 2;
  localparam int IRQ_EN_BIT  = 3;
  localparam int RX_CNT_LSB  = 8;
  localparam int RX_CNT_W    = 8;

  // Packed view, MSB first, so that a cast to logic [REG_W-1:0] gives the
  // exact software-visible layout.
  typedef struct packed {
    logic [RX_CNT_W-1:0] rx_cnt;   // [15:8] received byte count, wraps
    logic [3:0]          rsvd;     // [7:4]  always zero
    logic                irq_en;   // [3]
    logic                overrun;  // [2]    sticky until W1C
    logic                new_rx;   // [1]    byte waiting
    logic                send;     // [0]    transmit request
  } ch_reg_t;

endpackage

// File: rtl/module_uart_ctrl_bank_channel.sv
// One UART channel control/status register with its hardware event logic.
// Latency: register updates on the edge after a write/clear/event.
// Backpressure: none; every strobe and event is accepted on the cycle it appears.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   wr_en_i           write strobe, already decoded for this channel
//   clr_en_i          write-1-to-clear strobe, already decoded for this channel
//   wdata_i[3:0]      low write-data bits (only these are architecturally used)
//   send_done_i       transmit-complete pulse
//   rx_valid_i        byte-received pulse
//   reg_o             current register value (software layout)
//   send_o            SEND bit
//   irq_o             registered interrupt (only when UART_CTRL_IRQ_EN is defined)
//
// Build option: UART_CTRL_IRQ_EN enables the IRQ_EN bit and the irq_o output.
module module_uart_ctrl_channel
  import pkg_UART::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic             clr_en_i,
  input  logic [3:0]       wdata_i,
  input  logic             send_done_i,
  input  logic             rx_valid_i,
  output logic [REG_W-1:0] reg_o,
  output logic             send_o,
  output logic             irq_o
);

  ch_reg_t r_q;
  ch_reg_t r_d;
  logic    clr_new_rx;
  logic    clr_ovr;

  always_comb begin
    r_d        = r_q;
    // A normal write in the same cycle suppresses the clear strobe.
    clr_new_rx = clr_en_i && !wr_en_i && wdata_i[NEW_RX_BIT];
    clr_ovr    = clr_en_i && !wr_en_i && wdata_i[OVERRUN_BIT];

    // A software write always wins over the done pulse, so a fresh request
    // issued on the completion cycle is not lost.
    if (wr_en_i) begin
      r_d.send = wdata_i[SEND_BIT];
    end else if (send_done_i) begin
      r_d.send = 1'b0;
    end

`ifdef UART_CTRL_IRQ_EN
    if (wr_en_i) begin
      r_d.irq_en = wdata_i[IRQ_EN_BIT];
    end
`else
    r_d.irq_en = 1'b0;
`endif

    // Arrival sets NEW_RX even when software clears it on the same edge.
    if (rx_valid_i) begin
      r_d.new_rx = 1'b1;
      r_d.rx_cnt = r_q.rx_cnt + RX_CNT_W'(1);
    end else if (clr_new_rx) begin
      r_d.new_rx = 1'b0;
    end

    // Overrun only if the previous byte is still unacknowledged after this
    // edge's clear; a coincident NEW_RX clear consumes the old byte.
    if (rx_valid_i && r_q.new_rx && !clr_new_rx) begin
      r_d.overrun = 1'b1;
    end else if (clr_ovr) begin
      r_d.overrun = 1'b0;
    end

    r_d.rsvd = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign reg_o  = r_q;
  assign send_o = r_q.send;

`ifdef UART_CTRL_IRQ_EN
  // Registered from the updated state: one cycle behind the register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= r_q.irq_en && (r_q.new_rx || r_q.overrun);
    end
  end
`else
  logic unused_irq_en_bit;
  assign unused_irq_en_bit = wdata_i[IRQ_EN_BIT];
  assign irq_o             = 1'b0;
`endif

endmodule

// File: rtl/module_uart_ctrl_bank.sv
// Bank of N_CH UART control/status registers with a shared write/clear/read port.
// Latency: writes/clears/events take effect on the next edge; read data 1 cycle after rd_en_i.
// Backpressure: none; one access per cycle is always accepted, reads return unconditionally.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   wr_en_i, clr_en_i        write / write-1-to-clear strobes, target wr_ch_i
//   wr_ch_i, wdata_i         target channel and data for write/clear
//   rd_en_i, rd_ch_i         read request and channel
//   rdata_o, rvalid_o        registered read data and its one-cycle valid
//   send_done_i, rx_valid_i  per-channel hardware event pulses
//   send_o, irq_o            per-channel SEND bit and interrupt
//
// Build option: UART_CTRL_IRQ_EN enables IRQ_EN and irq_o; otherwise irq_o is 0.
module module_uart_ctrl_bank
  import pkg_UART::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int N_CH       = 4,
  localparam int CH_W       = $clog2(N_CH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic                  clr_en_i,
  input  logic [CH_W-1:0]       wr_ch_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rd_en_i,
  input  logic [CH_W-1:0]       rd_ch_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  input  logic [N_CH-1:0]       send_done_i,
  input  logic [N_CH-1:0]       rx_valid_i,
  output logic [N_CH-1:0]       send_o,
  output logic [N_CH-1:0]       irq_o
);

  logic [N_CH-1:0]       wr_sel;
  logic [N_CH-1:0]       clr_sel;
  logic [REG_W-1:0]      ch_reg [N_CH];
  logic [DATA_WIDTH-1:0] rd_word;

  // Only bits [3:0] of the write data have any architectural meaning.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i[DATA_WIDTH-1:4];

  // Channel decode: an index with no matching channel selects nothing,
  // which makes out-of-range writes and clears silently vanish.
  for (genvar n = 0; n < N_CH; n++) begin : g_ch
    assign wr_sel[n]  = wr_en_i  && (wr_ch_i == CH_W'(n));
    assign clr_sel[n] = clr_en_i && (wr_ch_i == CH_W'(n));

    module_uart_ctrl_channel u_ch (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .wr_en_i     (wr_sel[n]),
      .clr_en_i    (clr_sel[n]),
      .wdata_i     (wdata_i[3:0]),
      .send_done_i (send_done_i[n]),
      .rx_valid_i  (rx_valid_i[n]),
      .reg_o       (ch_reg[n]),
      .send_o      (send_o[n]),
      .irq_o       (irq_o[n])
    );
  end

  // Read mux samples the pre-update register values; an unmatched index
  // falls through to zero.
  always_comb begin
    rd_word = '0;
    for (int n = 0; n < N_CH; n++) begin
      if (rd_ch_i == CH_W'(n)) begin
        rd_word[REG_W-1:0] = ch_reg[n];
      end
    end
  end

  // rdata_o holds its last value between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
    end else begin
      rvalid_o <= rd_en_i;
      if (rd_en_i) begin
        rdata_o <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_module_uart_ctrl_bank.sv
// Self-checking bench for module_uart_ctrl_bank: directed scenarios plus a
// randomized run, all checked against a field-level behavioural model.
// A second small instance (3 channels, 16-bit bus) exercises out-of-range indices.
module tb_module_uart_ctrl_bank;

`ifdef UART_CTRL_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wr_en_i = 1'b0;
  logic        clr_en_i = 1'b0;
  logic [1:0]  wr_ch_i = '0;
  logic [31:0] wdata_i = '0;
  logic        rd_en_i = 1'b0;
  logic [1:0]  rd_ch_i = '0;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic [3:0]  send_done_i = '0;
  logic [3:0]  rx_valid_i = '0;
  logic [3:0]  send_o;
  logic [3:0]  irq_o;

  // Second instance signals
  logic [1:0]  wr_ch3 = 2'd3;
  logic [1:0]  rd_ch3 = 2'd3;
  logic [15:0] wdata3 = '0;
  logic [15:0] rdata3;
  logic        rvalid3;
  logic [2:0]  done3 = '0;
  logic [2:0]  rx3 = '0;
  logic [2:0]  send3;
  logic [2:0]  irq3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  module_uart_ctrl_bank #(.DATA_WIDTH(32), .N_CH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .clr_en_i(clr_en_i),
    .wr_ch_i(wr_ch_i), .wdata_i(wdata_i), .rd_en_i(rd_en_i), .rd_ch_i(rd_ch_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .send_done_i(send_done_i),
    .rx_valid_i(rx_valid_i), .send_o(send_o), .irq_o(irq_o)
  );

  module_uart_ctrl_bank #(.DATA_WIDTH(16), .N_CH(3)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .clr_en_i(clr_en_i),
    .wr_ch_i(wr_ch3), .wdata_i(wdata3), .rd_en_i(rd_en_i), .rd_ch_i(rd_ch3),
    .rdata_o(rdata3), .rvalid_o(rvalid3), .send_done_i(done3),
    .rx_valid_i(rx3), .send_o(send3), .irq_o(irq3)
  );

  // ---------------- reference model (per-field, spec rules) ----------------
  int          m_send [4];
  int          m_new  [4];
  int          m_ovr  [4];
  int          m_ien  [4];
  int          m_cnt  [4];
  int          m_irq  [4];
  logic [31:0] m_rdata  = '0;
  logic        m_rvalid = 1'b0;

  function automatic logic [31:0] exp_reg(int n);
    return 32'(m_send[n] + 2 * m_new[n] + 4 * m_ovr[n] + 8 * m_ien[n] + 256 * m_cnt[n]);
  endfunction

  function automatic logic [3:0] exp_send();
    logic [3:0] v;
    for (int n = 0; n < 4; n++) v[n] = (m_send[n] != 0);
    return v;
  endfunction

  function automatic logic [3:0] exp_irq();
    logic [3:0] v;
    for (int n = 0; n < 4; n++) v[n] = (m_irq[n] != 0);
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int taken;
    if (rst_i) begin
      for (int n = 0; n < 4; n++) begin
        m_send[n] = 0; m_new[n] = 0; m_ovr[n] = 0;
        m_ien[n] = 0; m_cnt[n] = 0; m_irq[n] = 0;
      end
      m_rdata  = '0;
      m_rvalid = 1'b0;
    end else begin
      m_rvalid = rd_en_i;
      if (rd_en_i) m_rdata = exp_reg(int'(rd_ch_i));
      for (int n = 0; n < 4; n++) begin
        m_irq[n] = (IRQ_ON && m_ien[n] != 0 && (m_new[n] != 0 || m_ovr[n] != 0)) ? 1 : 0;
      end
      for (int n = 0; n < 4; n++) begin
        bit w, c;
        w = wr_en_i && (int'(wr_ch_i) == n);
        c = clr_en_i && !wr_en_i && (int'(wr_ch_i) == n);
        if (w) m_send[n] = int'(wdata_i[0]);
        else if (send_done_i[n]) m_send[n] = 0;
        if (w && IRQ_ON) m_ien[n] = int'(wdata_i[3]);
        taken = (c && wdata_i[1]) ? 1 : 0;
        if (rx_valid_i[n] && m_new[n] != 0 && taken == 0) m_ovr[n] = 1;
        else if (c && wdata_i[2]) m_ovr[n] = 0;
        if (rx_valid_i[n]) begin
          m_new[n] = 1;
          m_cnt[n] = (m_cnt[n] + 1) % 256;
        end else if (taken != 0) begin
          m_new[n] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wr_en_i = 1'b0; clr_en_i = 1'b0; rd_en_i = 1'b0;
    send_done_i = '0; rx_valid_i = '0; wdata_i = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b1; idle();
    tick(); tick();
    n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", rdata_o); end
    n_cmp++; if (rvalid_o !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid got=%b exp=0", rvalid_o); end
    n_cmp++; if (send_o !== 4'b0) begin n_bad++; $display("FAIL reset_send got=%b exp=0", send_o); end
    n_cmp++; if (irq_o !== 4'b0) begin n_bad++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] lit;
    lit = IRQ_ON ? 32'h0000_0009 : 32'h0000_0001;
    idle(); wr_en_i = 1'b1; wr_ch_i = 2'd2; wdata_i = 32'h9;
    tick();
    idle(); rd_en_i = 1'b1; rd_ch_i = 2'd2;
    n_cmp++; if (rvalid_o !== 1'b0) begin n_bad++; $display("FAIL wr_rvalid_early got=%b exp=0", rvalid_o); end
    tick();
    n_cmp++; if (rvalid_o !== 1'b1) begin n_bad++; $display("FAIL rd_rvalid got=%b exp=1", rvalid_o); end
    n_cmp++; if (rdata_o !== lit) begin n_bad++; $display("FAIL rd_ch2 got=%h exp=%h", rdata_o, lit); end
    n_cmp++; if (send_o !== 4'b0100) begin n_bad++; $display("FAIL send_ch2 got=%b exp=0100", send_o); end
    idle();
    tick();
    n_cmp++; if (rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rvalid_pulse got=%b exp=0", rvalid_o); end
    n_cmp++; if (rdata_o !== lit) begin n_bad++; $display("FAIL rdata_hold got=%h exp=%h", rdata_o, lit); end
  endtask

  task automatic test_rx_overrun();
    idle();
    for (int i = 0; i < 3; i++) begin
      rx_valid_i = 4'b0010; tick();
    end
    idle(); rd_en_i = 1'b1; rd_ch_i = 2'd1;
    tick();
    idle();
    n_cmp++; if (rdata_o !== 32'h0000_0306) begin n_bad++; $display("FAIL rx3_ch1 got=%h exp=00000306", rdata_o); end
    n_cmp++; if (rdata_o !== m_rdata) begin n_bad++; $display("FAIL rx3_model got=%h exp=%h", rdata_o, m_rdata); end
  endtask

  task automatic test_wrap();
    idle();
    for (int i = 0; i < 256; i++) begin
      rx_valid_i = 4'b0001; tick();
      idle(); clr_en_i = 1'b1; wr_ch_i = 2'd0; wdata_i = 32'h6; tick();
      idle();
    end
    rd_en_i = 1'b1; rd_ch_i = 2'd0;
    tick();
    idle();
    n_cmp++; if (rdata_o[15:8] !== 8'h00) begin n_bad++; $display("FAIL wrap_cnt got=%h exp=00", rdata_o[15:8]); end
    n_cmp++; if (rdata_o[2] !== 1'b0) begin n_bad++; $display("FAIL wrap_ovr got=%b exp=0", rdata_o[2]); end
    n_cmp++; if (rdata_o !== m_rdata) begin n_bad++; $display("FAIL wrap_model got=%h exp=%h", rdata_o, m_rdata); end
  endtask

  task automatic test_collisions();
    idle(); rx_valid_i = 4'b1000; tick();
    // W1C of NEW_RX together with a fresh arrival
    idle(); clr_en_i = 1'b1; wr_ch_i = 2'd3; wdata_i = 32'h2; rx_valid_i = 4'b1000; tick();
    idle(); rd_en_i = 1'b1; rd_ch_i = 2'd3; tick();
    idle();
    n_cmp++; if (rdata_o[1] !== 1'b1) begin n_bad++; $display("FAIL coll_newrx got=%b exp=1", rdata_o[1]); end
    n_cmp++; if (rdata_o[2] !== 1'b0) begin n_bad++; $display("FAIL coll_ovr got=%b exp=0", rdata_o[2]); end
    n_cmp++; if (rdata_o !== m_rdata) begin n_bad++; $display("FAIL coll_model got=%h exp=%h", rdata_o, m_rdata); end
    // SEND request together with the done pulse
    wr_en_i = 1'b1; wr_ch_i = 2'd3; wdata_i = 32'h1; send_done_i = 4'b1000; tick();
    idle();
    n_cmp++; if (send_o[3] !== 1'b1) begin n_bad++; $display("FAIL coll_send got=%b exp=1", send_o[3]); end
    send_done_i = 4'b1000; tick();
    idle();
    n_cmp++; if (send_o[3] !== 1'b0) begin n_bad++; $display("FAIL done_clr got=%b exp=0", send_o[3]); end
  endtask

  task automatic test_irq();
    idle(); wr_en_i = 1'b1; wr_ch_i = 2'd0; wdata_i = 32'h8; tick();
    idle(); rx_valid_i = 4'b0001; tick();
    idle();
    n_cmp++; if (irq_o[0] !== 1'b0) begin n_bad++; $display("FAIL irq_early got=%b exp=0", irq_o[0]); end
    tick();
    n_cmp++; if (irq_o[0] !== IRQ_ON) begin n_bad++; $display("FAIL irq_set got=%b exp=%b", irq_o[0], IRQ_ON); end
    clr_en_i = 1'b1; wr_ch_i = 2'd0; wdata_i = 32'h6; tick();
    idle(); tick();
    n_cmp++; if (irq_o[0] !== 1'b0) begin n_bad++; $display("FAIL irq_clr got=%b exp=0", irq_o[0]); end
  endtask

  task automatic test_random();
    idle();
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst_i       = ($urandom_range(0, 59) == 0);
      wr_en_i     = ($urandom_range(0, 3) == 0);
      clr_en_i    = ($urandom_range(0, 2) == 0);
      wr_ch_i     = 2'($urandom_range(0, 3));
      wdata_i     = $urandom;
      rd_en_i     = $urandom_range(0, 1) == 1;
      rd_ch_i     = 2'($urandom_range(0, 3));
      send_done_i = 4'($urandom) & 4'($urandom);
      rx_valid_i  = 4'($urandom) & 4'($urandom);
      tick();
      n_cmp++; if (send_o !== exp_send()) begin n_bad++; $display("FAIL rnd_send cyc=%0d got=%b exp=%b", cyc, send_o, exp_send()); end
      n_cmp++; if (irq_o !== exp_irq()) begin n_bad++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", cyc, irq_o, exp_irq()); end
      n_cmp++; if (rvalid_o !== m_rvalid) begin n_bad++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, rvalid_o, m_rvalid); end
      n_cmp++; if (rdata_o !== m_rdata) begin n_bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, rdata_o, m_rdata); end
    end
    rst_i = 1'b0; idle();
  endtask

  task automatic test_reset_mid();
    idle(); wr_en_i = 1'b1; wr_ch_i = 2'd1; wdata_i = 32'h9; tick();
    idle(); rd_en_i = 1'b1; rd_ch_i = 2'd1; rx_valid_i = 4'b1111; tick();
    // Reset with every kind of event pending at once
    rst_i = 1'b1; wr_en_i = 1'b1; wr_ch_i = 2'd2; wdata_i = 32'hF;
    rd_en_i = 1'b1; rx_valid_i = 4'b1111; send_done_i = 4'b1111;
    tick();
    n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL mid_rdata got=%h exp=0", rdata_o); end
    n_cmp++; if (rvalid_o !== 1'b0) begin n_bad++; $display("FAIL mid_rvalid got=%b exp=0", rvalid_o); end
    n_cmp++; if (send_o !== 4'b0) begin n_bad++; $display("FAIL mid_send got=%b exp=0", send_o); end
    n_cmp++; if (irq_o !== 4'b0) begin n_bad++; $display("FAIL mid_irq got=%b exp=0", irq_o); end
    rst_i = 1'b0; idle();
    for (int n = 0; n < 4; n++) begin
      rd_en_i = 1'b1; rd_ch_i = 2'(n); tick();
      n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL mid_reg ch=%0d got=%h exp=0", n, rdata_o); end
    end
    idle();
  endtask

  task automatic test_out_of_range();
    // dut3 has channels 0..2; index 3 must be inert on write, clear and read.
    idle();
    wr_ch3 = 2'd3; wdata3 = 16'h000F; wr_en_i = 1'b1; tick();
    idle(); rd_en_i = 1'b1; rd_ch3 = 2'd3; tick();
    idle();
    n_cmp++; if (rvalid3 !== 1'b1) begin n_bad++; $display("FAIL oor_rvalid got=%b exp=1", rvalid3); end
    n_cmp++; if (rdata3 !== 16'h0) begin n_bad++; $display("FAIL oor_rdata got=%h exp=0", rdata3); end
    n_cmp++; if (send3 !== 3'b0) begin n_bad++; $display("FAIL oor_send got=%b exp=0", send3); end
    // An in-range write on dut3 does take effect
    wr_ch3 = 2'd0; wdata3 = 16'h0001; wr_en_i = 1'b1; tick();
    idle(); rd_en_i = 1'b1; rd_ch3 = 2'd0; tick();
    idle(); wr_ch3 = 2'd3; rd_ch3 = 2'd3;
    n_cmp++; if (rdata3 !== 16'h0001) begin n_bad++; $display("FAIL inr_rdata got=%h exp=0001", rdata3); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rx_overrun();
    test_wrap();
    test_collisions();
    test_irq();
    test_random();
    test_reset_mid();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/module_uart_ctrl_bank.md
MODULE_UART_CTRL_BANK -- requirements
Module: module_uart_ctrl_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register/bus width; legal values >= 16.
REQ-002 SHALL have parameter N_CH, default 4, number of UART channels; legal values >= 2.
REQ-003 SHALL have localparam CH_W = $clog2(N_CH).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port wr_en_i, input, 1, normal write strobe.
REQ-007 SHALL have port clr_en_i, input, 1, write-1-to-clear strobe.
REQ-008 SHALL have port wr_ch_i, input, CH_W, target channel for wr_en_i and clr_en_i.
REQ-009 SHALL have port wdata_i, input, DATA_WIDTH, write data.
REQ-010 SHALL have port rd_en_i, input, 1, read request.
REQ-011 SHALL have port rd_ch_i, input, CH_W, read channel.
REQ-012 SHALL have port rdata_o, output, DATA_WIDTH, registered read data.
REQ-013 SHALL have port rvalid_o, output, 1, rdata_o valid pulse.
REQ-014 SHALL have port send_done_i, input, N_CH, per-channel transmit-complete pulse.
REQ-015 SHALL have port rx_valid_i, input, N_CH, per-channel byte-received pulse.
REQ-016 SHALL have port send_o, output, N_CH, per-channel SEND bit.
REQ-017 SHALL have port irq_o, output, N_CH, per-channel interrupt.

Function
REQ-018 SHALL lay out each channel register as: bit0 SEND, bit1 NEW_RX, bit2 OVERRUN, bit3 IRQ_EN, bits[15:8] RX_CNT; all other bits read 0.
REQ-019 SHALL, on wr_en_i, load SEND and IRQ_EN of channel wr_ch_i from wdata_i; NEW_RX, OVERRUN and RX_CNT are not writable this way.
REQ-020 SHALL, on clr_en_i, clear NEW_RX and/or OVERRUN of channel wr_ch_i where wdata_i bit1 and/or bit2 is 1.
REQ-021 SHALL ignore clr_en_i when wr_en_i is asserted in the same cycle (wr_en_i has priority).
REQ-022 SHALL clear SEND on send_done_i[n] in the cycle after the pulse.
REQ-023 SHALL, when a software write sets SEND=1 on channel n in the same cycle as send_done_i[n], leave SEND=1 (the new request wins).
REQ-024 SHALL, on rx_valid_i[n], set NEW_RX and increment RX_CNT modulo 256 (255 -> 0).
REQ-025 SHALL set OVERRUN when rx_valid_i[n] arrives while NEW_RX is already 1; OVERRUN is sticky until W1C or reset.
REQ-026 SHALL, when a W1C of NEW_RX coincides with rx_valid_i[n], leave NEW_RX=1 (set wins; no event is lost), with no overrun.
REQ-027 SHALL process hardware events on all channels independently and in the same cycle as a software access to any channel.
REQ-028 SHALL, on rd_en_i, drive rdata_o with the register of rd_ch_i and pulse rvalid_o for one cycle; latency is 1 cycle; read data is the register value before that edge's updates.
REQ-029 SHALL, when rd_ch_i or wr_ch_i >= N_CH, make the read return 0 and the write or clear have no effect.
REQ-030 SHALL drive send_o[n] directly from SEND of channel n.
REQ-031 SHALL, when rd_en_i is low, hold rdata_o at its last value with rvalid_o = 0.

Reset
REQ-032 SHALL, while rst_i = 1 at a clock edge, clear all channel registers, rdata_o, rvalid_o, send_o and irq_o to 0.
REQ-033 SHALL give reset priority over every write, clear, read and hardware event; events present during reset are discarded.

Configuration
REQ-034 SHALL, with UART_CTRL_IRQ_EN defined, register irq_o[n] = IRQ_EN & (NEW_RX | OVERRUN), one cycle after the register update.
REQ-035 SHALL, with UART_CTRL_IRQ_EN undefined, tie irq_o to 0, make IRQ_EN read 0 and make IRQ_EN ignore writes.

Structure
REQ-036 SHALL place the bit-position constants, the RX_CNT width (8) and a packed struct typedef of the channel register in package pkg_UART.
REQ-037 SHALL implement one channel's register and event logic in sub-module module_uart_ctrl_channel, instantiated N_CH times via generate; read mux and rvalid logic stay in the top.

Verification
REQ-038 SHALL cover: reset, then wr_en_i ch2 wdata 0x9 -> read ch2 gives 0x0000_0009, send_o = 4'b0100, rvalid_o one cycle after rd_en_i.
REQ-039 SHALL cover: 3 rx_valid_i[1] pulses with no clear -> ch1 reads 0x0000_0306 (RX_CNT=3, OVERRUN, NEW_RX).
REQ-040 SHALL cover: 256 rx_valid_i[0] pulses, W1C 0x6 between each -> RX_CNT wraps to 0x00, OVERRUN=0.
REQ-041 SHALL cover: W1C 0x2 on ch3 in the same cycle as rx_valid_i[3] -> NEW_RX=1, OVERRUN=0; and wr SEND=1 with send_done_i[3] in the same cycle -> SEND=1.
REQ-042 SHALL cover: with UART_CTRL_IRQ_EN, IRQ_EN=1 plus rx_valid_i[0] -> irq_o[0]=1 two cycles after the pulse, then 0 after W1C 0x6; without the macro, irq_o stays 0.
REQ-043 SHALL cover: rst_i asserted mid-sequence with pending events -> all outputs 0 at the next edge; rd_ch_i = N_CH returns 0.
